arbitro_somador: RTL and testbench

ARBITRO_SOMADOR -- requirements
Module: arbitro_somador

---
 rtl/arbitro_somador.sv | 66 ++++++
 tb/tb_arbitro_somador.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/arbitro_somador.sv
// arbitro_somador: round-robin arbiter for three requesters feeding a registered adder.
// One transaction at a time: grant, sum, then hold the result until the consumer accepts it.
module arbitro_somador #(
    parameter int LARGURA = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2:0]             req,
    input  logic [3*LARGURA-1:0]   entradas1,
    input  logic [3*LARGURA-1:0]   entradas2,
    input  logic                   aceito,
    output logic [2:0]             grant,
    output logic [LARGURA-1:0]     resultado,
    output logic                   vai_um,
    output logic [1:0]             id,
    output logic                   valido,
    output logic                   ocupado
);
    typedef enum logic [1:0] {OCIOSO, SOMA, RESPOSTA} estado_t;
    estado_t estado, proximo;
    logic [1:0] ponteiro, p1, p2, escolha, indice;
    logic [3:0] req_ext;
    logic [LARGURA-1:0] op1, op2;
    logic captura;
    always_comb begin
        req_ext = {1'b0, req};
        p1 = ponteiro == 2'd2 ? 2'd0 : ponteiro + 2'd1;
        p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
        escolha = req_ext[ponteiro] ? ponteiro : req_ext[p1] ? p1 : p2;
        captura = estado == OCIOSO && |req;
        proximo = estado == OCIOSO ? (|req ? SOMA : OCIOSO) :
                  estado == SOMA   ? RESPOSTA :
                  aceito           ? OCIOSO : RESPOSTA;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) estado <= OCIOSO;
        else estado <= proximo;
    // id follows resultado, so it is only refreshed on the sum edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant <= '0;
            ponteiro <= '0;
            indice <= '0;
            op1 <= '0;
            op2 <= '0;
            resultado <= '0;
            vai_um <= 1'b0;
            id <= '0;
        end else begin
            grant <= '0;
            if (captura) begin
                grant <= 3'b001 << escolha;
                op1 <= entradas1[escolha*LARGURA +: LARGURA];
                op2 <= entradas2[escolha*LARGURA +: LARGURA];
                indice <= escolha;
                ponteiro <= escolha == 2'd2 ? 2'd0 : escolha + 2'd1;
            end
            if (estado == SOMA) begin
                {vai_um, resultado} <= {1'b0, op1} + {1'b0, op2};
                id <= indice;
            end
        end
    end
    assign valido = estado == RESPOSTA;
    assign ocupado = estado != OCIOSO;
endmodule

// File: tb/tb_arbitro_somador.sv
// tb_arbitro_somador: directed vectors plus hand-written multi-cycle sequences.
module tb_arbitro_somador;
    localparam int W = 32;
    logic clock = 1'b0, reset = 1'b1, aceito = 1'b0;
    logic [2:0] req = '0;
    logic [3*W-1:0] entradas1 = '0, entradas2 = '0;
    logic [2:0] grant;
    logic [W-1:0] resultado;
    logic vai_um, valido, ocupado;
    logic [1:0] id;
    int total = 0, bad = 0;

    arbitro_somador #(.LARGURA(W)) dut (
        .clock(clock), .reset(reset), .req(req), .entradas1(entradas1),
        .entradas2(entradas2), .aceito(aceito), .grant(grant),
        .resultado(resultado), .vai_um(vai_um), .id(id),
        .valido(valido), .ocupado(ocupado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]   req;
        int           slot;
        logic [W-1:0] a, b;
        logic [2:0]   g;
        logic [W-1:0] s;
        logic         c;
    } vec_t;
    vec_t v[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_ops(input int s, input logic [W-1:0] a, input logic [W-1:0] b);
        entradas1[s*W +: W] = a;
        entradas2[s*W +: W] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        aceito = 1'b0;
        @(negedge clock);
        chk("rst_grant", 64'(grant), 0);
        chk("rst_valido", 64'(valido), 0);
        chk("rst_ocupado", 64'(ocupado), 0);
        chk("rst_resultado", 64'(resultado), 0);
        reset = 1'b0;
    endtask

    logic [2:0] rr[10];

    initial begin
        v[0] = '{3'b001, 0, 32'd1, 32'd3, 3'b001, 32'd4, 1'b0};
        v[1] = '{3'b100, 2, 32'hFFFFFFFF, 32'h2, 3'b100, 32'h1, 1'b1};
        v[2] = '{3'b011, 0, 32'd10, 32'd20, 3'b001, 32'd30, 1'b0};
        v[3] = '{3'b011, 1, 32'd7, 32'd8, 3'b010, 32'd15, 1'b0};
        v[4] = '{3'b101, 2, 32'h80000000, 32'h80000000, 3'b100, 32'h0, 1'b1};
        v[5] = '{3'b110, 1, 32'h1, 32'hFFFFFFFF, 3'b010, 32'h0, 1'b1};
        v[6] = '{3'b011, 0, 32'h12345678, 32'h11111111, 3'b001, 32'h23456789, 1'b0};
        v[7] = '{3'b110, 1, 32'hAAAAAAAA, 32'h55555555, 3'b010, 32'hFFFFFFFF, 1'b0};
        rr = '{3'b001, 0, 0, 3'b010, 0, 0, 3'b100, 0, 0, 3'b001};

        @(negedge clock);
        do_reset();

        // table: one full transaction per vector, aceito held high throughout
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 3; k++) set_ops(k, 32'hDEAD0000 + k, 32'h00BE0000 + k);
            set_ops(v[i].slot, v[i].a, v[i].b);
            req = v[i].req;
            aceito = 1'b1;
            step();
            chk($sformatf("v%0d_grant", i), 64'(grant), 64'(v[i].g));
            chk($sformatf("v%0d_ocupado", i), 64'(ocupado), 1);
            chk($sformatf("v%0d_valido_soma", i), 64'(valido), 0);
            req = '0;
            step();
            chk($sformatf("v%0d_valido", i), 64'(valido), 1);
            chk($sformatf("v%0d_resultado", i), 64'(resultado), 64'(v[i].s));
            chk($sformatf("v%0d_vai_um", i), 64'(vai_um), 64'(v[i].c));
            chk($sformatf("v%0d_id", i), 64'(id), 64'(v[i].slot));
            chk($sformatf("v%0d_grant_off", i), 64'(grant), 0);
            step();
            chk($sformatf("v%0d_valido_clr", i), 64'(valido), 0);
            chk($sformatf("v%0d_ocupado_clr", i), 64'(ocupado), 0);
            chk($sformatf("v%0d_hold", i), 64'(resultado), 64'(v[i].s));
        end

        // round robin with all requests held
        do_reset();
        req = 3'b111;
        aceito = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("rr_grant_%0d", c), 64'(grant), 64'(rr[c]));
        end
        req = '0;
        step();
        step();

        // back-pressure: result held, pending request waits
        do_reset();
        set_ops(0, 32'd5, 32'd6);
        set_ops(1, 32'd100, 32'd1);
        req = 3'b001;
        aceito = 1'b0;
        step();
        chk("bp_grant0", 64'(grant), 64'(3'b001));
        req = 3'b010;
        step();
        chk("bp_valido", 64'(valido), 1);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp_hold_valido_%0d", c), 64'(valido), 1);
            chk($sformatf("bp_hold_res_%0d", c), 64'(resultado), 11);
            chk($sformatf("bp_hold_id_%0d", c), 64'(id), 0);
            chk($sformatf("bp_no_grant_%0d", c), 64'(grant), 0);
        end
        aceito = 1'b1;
        step();
        aceito = 1'b0;
        chk("bp_valido_clr", 64'(valido), 0);
        chk("bp_idle_grant", 64'(grant), 0);
        chk("bp_res_kept", 64'(resultado), 11);
        step();
        chk("bp_grant1", 64'(grant), 64'(3'b010));
        chk("bp_id_kept", 64'(id), 0);
        req = '0;
        step();
        chk("bp_res1", 64'(resultado), 101);
        chk("bp_id1", 64'(id), 1);
        aceito = 1'b1;
        step();

        // asynchronous reset in SOMA and in RESPOSTA
        do_reset();
        set_ops(0, 32'd2, 32'd2);
        set_ops(1, 32'd40, 32'd2);
        req = 3'b001;
        step();
        chk("rs_grant", 64'(grant), 64'(3'b001));
        #2 reset = 1'b1;
        #1;
        chk("rs_grant_async", 64'(grant), 0);
        chk("rs_valido_async", 64'(valido), 0);
        chk("rs_ocupado_async", 64'(ocupado), 0);
        @(negedge clock);
        reset = 1'b0;
        req = 3'b110;
        aceito = 1'b0;
        step();
        chk("rs_grant_after", 64'(grant), 64'(3'b010));
        req = '0;
        step();
        chk("rr_resp_valido", 64'(valido), 1);
        chk("rr_resp_res", 64'(resultado), 42);
        #2 reset = 1'b1;
        #1;
        chk("rr_valido_async", 64'(valido), 0);
        chk("rr_res_async", 64'(resultado), 0);
        chk("rr_id_async", 64'(id), 0);
        @(negedge clock);
        reset = 1'b0;

        // operand change after grant does not affect the sum
        set_ops(0, 32'd5, 32'd1);
        req = 3'b001;
        aceito = 1'b1;
        step();
        chk("oc_grant", 64'(grant), 64'(3'b001));
        entradas1[0 +: W] = 32'd9;
        req = '0;
        step();
        chk("oc_res", 64'(resultado), 6);
        step();
        chk("oc_idle", 64'(ocupado), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
